// File: rtl/candy_id_pkg.sv
// Shared decode constants for the candy_id instruction-decode stage:
// opcode/funct encodings, ALU operation codes and the decode helper.
package candy_id_pkg;

  localparam int INST_W = 32;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  // SPECIAL funct codes
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2a;

  // ALU operation codes handed to the execute stage
  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_XOR = 4'd5;
  localparam logic [3:0] ALU_SLT = 4'd6;
  localparam logic [3:0] ALU_LUI = 4'd7;

  // How the second operand is formed
  typedef enum logic [1:0] {
    IMM_NONE = 2'd0,   // op2 comes from the rt read port
    IMM_ZEXT = 2'd1,   // zero-extended imm16
    IMM_SEXT = 2'd2,   // sign-extended imm16
    IMM_LUI  = 2'd3    // imm16 << 16
  } imm_sel_e;

  // Which instruction field names the destination register
  typedef enum logic [1:0] {
    DST_NONE = 2'd0,
    DST_RD   = 2'd1,
    DST_RT   = 2'd2
  } dst_sel_e;

  typedef struct packed {
    logic     uses_rs;
    logic     uses_rt;
    logic [3:0] aluop;
    imm_sel_e imm_sel;
    dst_sel_e dst_sel;
    logic     mem_re;
    logic     mem_we;
    logic     invalid;
    logic     is_beq;
    logic     is_bne;
  } dec_t;

  // Static decode of one instruction word; unknown encodings come back as
  // an all-quiet record with only the invalid flag raised.
  function automatic dec_t decode_inst(input logic [INST_W-1:0] inst);
    dec_t       d;
    logic [5:0] op;
    logic [5:0] fn;
    op = inst[31:26];
    fn = inst[5:0];
    d  = '0;
    case (op)
      OP_SPECIAL: begin
        d.uses_rs = 1'b1;
        d.uses_rt = 1'b1;
        d.dst_sel = DST_RD;
        case (fn)
          FN_ADDU: d.aluop = ALU_ADD;
          FN_SUBU: d.aluop = ALU_SUB;
          FN_AND:  d.aluop = ALU_AND;
          FN_OR:   d.aluop = ALU_OR;
          FN_XOR:  d.aluop = ALU_XOR;
          FN_SLT:  d.aluop = ALU_SLT;
          default: begin
            d         = '0;
            d.invalid = 1'b1;
          end
        endcase
      end
      OP_ORI: begin
        d.uses_rs = 1'b1; d.aluop = ALU_OR;  d.imm_sel = IMM_ZEXT; d.dst_sel = DST_RT;
      end
      OP_ANDI: begin
        d.uses_rs = 1'b1; d.aluop = ALU_AND; d.imm_sel = IMM_ZEXT; d.dst_sel = DST_RT;
      end
      OP_XORI: begin
        d.uses_rs = 1'b1; d.aluop = ALU_XOR; d.imm_sel = IMM_ZEXT; d.dst_sel = DST_RT;
      end
      OP_ADDIU: begin
        d.uses_rs = 1'b1; d.aluop = ALU_ADD; d.imm_sel = IMM_SEXT; d.dst_sel = DST_RT;
      end
      OP_LW: begin
        d.uses_rs = 1'b1; d.aluop = ALU_ADD; d.imm_sel = IMM_SEXT; d.dst_sel = DST_RT;
        d.mem_re  = 1'b1;
      end
      OP_SW: begin
        d.uses_rs = 1'b1; d.uses_rt = 1'b1; d.aluop = ALU_ADD; d.imm_sel = IMM_SEXT;
        d.mem_we  = 1'b1;
      end
      OP_LUI: begin
        d.aluop = ALU_LUI; d.imm_sel = IMM_LUI; d.dst_sel = DST_RT;
      end
      OP_BEQ: begin
        d.uses_rs = 1'b1; d.uses_rt = 1'b1; d.is_beq = 1'b1;
      end
      OP_BNE: begin
        d.uses_rs = 1'b1; d.uses_rt = 1'b1; d.is_bne = 1'b1;
      end
      default: d.invalid = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/candy_id_fwd.sv
// Per-port operand select: r0/disabled port reads zero, then the EX result,
// then the MEM result, then the register file.
module candy_id_fwd #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               en,
  input  logic [RADDR_W-1:0] addr,
  input  logic [DATA_W-1:0]  rdata,
  input  logic               exf_we,
  input  logic [RADDR_W-1:0] exf_waddr,
  input  logic [DATA_W-1:0]  exf_wdata,
  input  logic               memf_we,
  input  logic [RADDR_W-1:0] memf_waddr,
  input  logic [DATA_W-1:0]  memf_wdata,
  output logic [DATA_W-1:0]  data
);

  // Priority mux: the youngest in-flight result wins over older ones
  always_comb begin
    data = rdata;
    if (!en || (addr == '0)) begin
      data = '0;
    end else if (exf_we && (exf_waddr == addr)) begin
      data = exf_wdata;
    end else if (memf_we && (memf_waddr == addr)) begin
      data = memf_wdata;
    end
  end

endmodule

// File: rtl/candy_id.sv
// Instruction-decode stage: decodes the fetched word, reads the register
// file, forwards EX/MEM results, detects load-use hazards, resolves
// BEQ/BNE and holds the ID/EX pipeline register.
module candy_id
  import candy_id_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int PC_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [INST_W-1:0]  id_inst,
  input  logic [PC_W-1:0]    id_pc,
  input  logic               stall_in,
  input  logic               flush,
  output logic               re1,
  output logic               re2,
  output logic [RADDR_W-1:0] raddr1,
  output logic [RADDR_W-1:0] raddr2,
  input  logic [DATA_W-1:0]  rdata1,
  input  logic [DATA_W-1:0]  rdata2,
  input  logic               exf_we,
  input  logic [RADDR_W-1:0] exf_waddr,
  input  logic [DATA_W-1:0]  exf_wdata,
  input  logic               memf_we,
  input  logic [RADDR_W-1:0] memf_waddr,
  input  logic [DATA_W-1:0]  memf_wdata,
  output logic               stall_req,
  output logic               br_taken,
  output logic [PC_W-1:0]    br_target,
  output logic [3:0]         ex_aluop,
  output logic [DATA_W-1:0]  ex_op1,
  output logic [DATA_W-1:0]  ex_op2,
  output logic [DATA_W-1:0]  ex_store_data,
  output logic [RADDR_W-1:0] ex_waddr,
  output logic               ex_we,
  output logic               ex_mem_re,
  output logic               ex_mem_we,
  output logic               ex_invalid
);

  logic [RADDR_W-1:0] rs;
  logic [RADDR_W-1:0] rt;
  logic [RADDR_W-1:0] rd;
  logic [15:0]        imm;
  dec_t               dec;

  logic [DATA_W-1:0]  opa;
  logic [DATA_W-1:0]  opb;
  logic [DATA_W-1:0]  imm_ext;
  logic [RADDR_W-1:0] dst_addr;
  logic               hazard1;
  logic               hazard2;

  logic [3:0]         ex_aluop_d,      ex_aluop_q;
  logic [DATA_W-1:0]  ex_op1_d,        ex_op1_q;
  logic [DATA_W-1:0]  ex_op2_d,        ex_op2_q;
  logic [DATA_W-1:0]  ex_store_data_d, ex_store_data_q;
  logic [RADDR_W-1:0] ex_waddr_d,      ex_waddr_q;
  logic               ex_we_d,         ex_we_q;
  logic               ex_mem_re_d,     ex_mem_re_q;
  logic               ex_mem_we_d,     ex_mem_we_q;
  logic               ex_invalid_d,    ex_invalid_q;

  assign rs  = id_inst[21 +: RADDR_W];
  assign rt  = id_inst[16 +: RADDR_W];
  assign rd  = id_inst[11 +: RADDR_W];
  assign imm = id_inst[15:0];
  assign dec = decode_inst(id_inst);

  // Read ports: addresses always follow the fields, enables follow usage
  assign re1    = dec.uses_rs;
  assign re2    = dec.uses_rt;
  assign raddr1 = rs;
  assign raddr2 = rt;

  candy_id_fwd #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_fwd1 (
    .en         (re1),
    .addr       (raddr1),
    .rdata      (rdata1),
    .exf_we     (exf_we),
    .exf_waddr  (exf_waddr),
    .exf_wdata  (exf_wdata),
    .memf_we    (memf_we),
    .memf_waddr (memf_waddr),
    .memf_wdata (memf_wdata),
    .data       (opa)
  );

  candy_id_fwd #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_fwd2 (
    .en         (re2),
    .addr       (raddr2),
    .rdata      (rdata2),
    .exf_we     (exf_we),
    .exf_waddr  (exf_waddr),
    .exf_wdata  (exf_wdata),
    .memf_we    (memf_we),
    .memf_waddr (memf_waddr),
    .memf_wdata (memf_wdata),
    .data       (opb)
  );

  // Immediate formation for the second operand
  always_comb begin
    imm_ext = '0;
    case (dec.imm_sel)
      IMM_ZEXT: imm_ext = {{(DATA_W-16){1'b0}}, imm};
      IMM_SEXT: imm_ext = {{(DATA_W-16){imm[15]}}, imm};
      IMM_LUI:  imm_ext = {imm, {(DATA_W-16){1'b0}}};
      default:  imm_ext = '0;
    endcase
  end

  // Destination selection; r0 is never a real destination
  always_comb begin
    dst_addr = '0;
    case (dec.dst_sel)
      DST_RD:  dst_addr = rd;
      DST_RT:  dst_addr = rt;
      default: dst_addr = '0;
    endcase
  end

  // A load in EX cannot forward yet, so a dependent consumer must wait a cycle
  assign hazard1   = re1 && (ex_waddr_q == raddr1);
  assign hazard2   = re2 && (ex_waddr_q == raddr2);
  assign stall_req = id_valid && ex_mem_re_q && (ex_waddr_q != '0) && (hazard1 || hazard2);

  // Branches compare the forwarded operands so they see in-flight results
  assign br_taken  = id_valid && !stall_req &&
                     ((dec.is_beq && (opa == opb)) || (dec.is_bne && (opa != opb)));
  assign br_target = id_pc + PC_W'(4) + {{(PC_W-18){imm[15]}}, imm, 2'b00};

  // ID/EX next state: flush beats downstream stall, which beats a bubble
  always_comb begin
    ex_aluop_d      = ex_aluop_q;
    ex_op1_d        = ex_op1_q;
    ex_op2_d        = ex_op2_q;
    ex_store_data_d = ex_store_data_q;
    ex_waddr_d      = ex_waddr_q;
    ex_we_d         = ex_we_q;
    ex_mem_re_d     = ex_mem_re_q;
    ex_mem_we_d     = ex_mem_we_q;
    ex_invalid_d    = ex_invalid_q;
    if (flush || (!stall_in && (stall_req || !id_valid))) begin
      ex_aluop_d      = ALU_NOP;
      ex_op1_d        = '0;
      ex_op2_d        = '0;
      ex_store_data_d = '0;
      ex_waddr_d      = '0;
      ex_we_d         = 1'b0;
      ex_mem_re_d     = 1'b0;
      ex_mem_we_d     = 1'b0;
      ex_invalid_d    = 1'b0;
    end else if (!stall_in) begin
      ex_aluop_d      = dec.aluop;
      ex_op1_d        = opa;
      ex_op2_d        = (dec.imm_sel == IMM_NONE) ? opb : imm_ext;
      ex_store_data_d = dec.mem_we ? opb : '0;
      ex_waddr_d      = dst_addr;
      ex_we_d         = (dec.dst_sel != DST_NONE) && (dst_addr != '0);
      ex_mem_re_d     = dec.mem_re;
      ex_mem_we_d     = dec.mem_we;
      ex_invalid_d    = dec.invalid;
    end
  end

  // ID/EX register, cleared immediately by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_aluop_q      <= ALU_NOP;
      ex_op1_q        <= '0;
      ex_op2_q        <= '0;
      ex_store_data_q <= '0;
      ex_waddr_q      <= '0;
      ex_we_q         <= 1'b0;
      ex_mem_re_q     <= 1'b0;
      ex_mem_we_q     <= 1'b0;
      ex_invalid_q    <= 1'b0;
    end else begin
      ex_aluop_q      <= ex_aluop_d;
      ex_op1_q        <= ex_op1_d;
      ex_op2_q        <= ex_op2_d;
      ex_store_data_q <= ex_store_data_d;
      ex_waddr_q      <= ex_waddr_d;
      ex_we_q         <= ex_we_d;
      ex_mem_re_q     <= ex_mem_re_d;
      ex_mem_we_q     <= ex_mem_we_d;
      ex_invalid_q    <= ex_invalid_d;
    end
  end

  assign ex_aluop      = ex_aluop_q;
  assign ex_op1        = ex_op1_q;
  assign ex_op2        = ex_op2_q;
  assign ex_store_data = ex_store_data_q;
  assign ex_waddr      = ex_waddr_q;
  assign ex_we         = ex_we_q;
  assign ex_mem_re     = ex_mem_re_q;
  assign ex_mem_we     = ex_mem_we_q;
  assign ex_invalid    = ex_invalid_q;

endmodule

// File: tb/tb_candy_id.sv
// Directed testbench for candy_id with hand-computed expectations.
module tb_candy_id;

  localparam int DATA_W  = 32;
  localparam int RADDR_W = 5;
  localparam int PC_W    = 32;

  logic               clk;
  logic               rst;
  logic               id_valid;
  logic [31:0]        id_inst;
  logic [PC_W-1:0]    id_pc;
  logic               stall_in;
  logic               flush;
  logic               re1, re2;
  logic [RADDR_W-1:0] raddr1, raddr2;
  logic [DATA_W-1:0]  rdata1, rdata2;
  logic               exf_we;
  logic [RADDR_W-1:0] exf_waddr;
  logic [DATA_W-1:0]  exf_wdata;
  logic               memf_we;
  logic [RADDR_W-1:0] memf_waddr;
  logic [DATA_W-1:0]  memf_wdata;
  logic               stall_req;
  logic               br_taken;
  logic [PC_W-1:0]    br_target;
  logic [3:0]         ex_aluop;
  logic [DATA_W-1:0]  ex_op1, ex_op2, ex_store_data;
  logic [RADDR_W-1:0] ex_waddr;
  logic               ex_we, ex_mem_re, ex_mem_we, ex_invalid;

  int vectors = 0;
  int errs    = 0;

  candy_id #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
    .stall_in(stall_in), .flush(flush),
    .re1(re1), .re2(re2), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2),
    .exf_we(exf_we), .exf_waddr(exf_waddr), .exf_wdata(exf_wdata),
    .memf_we(memf_we), .memf_waddr(memf_waddr), .memf_wdata(memf_wdata),
    .stall_req(stall_req), .br_taken(br_taken), .br_target(br_target),
    .ex_aluop(ex_aluop), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_store_data(ex_store_data), .ex_waddr(ex_waddr), .ex_we(ex_we),
    .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we), .ex_invalid(ex_invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fwd_off();
    exf_we = 1'b0; exf_waddr = '0; exf_wdata = '0;
    memf_we = 1'b0; memf_waddr = '0; memf_wdata = '0;
  endtask

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_inst = '0; id_pc = '0;
    stall_in = 1'b0; flush = 1'b0; rdata1 = '0; rdata2 = '0;
    fwd_off();
    tick(); tick();
    chk("rst_aluop", ex_aluop, 0);
    chk("rst_we", ex_we, 0);
    chk("rst_op1", ex_op1, 0);
    chk("rst_invalid", ex_invalid, 0);
    chk("rst_stall_req", stall_req, 0);
    chk("rst_br_taken", br_taken, 0);
    rst = 1'b0;

    // ORI r1,r0,0x00ff
    id_valid = 1'b1; id_inst = 32'h340100ff;
    #1;
    chk("ori_re1", re1, 1);
    chk("ori_re2", re2, 0);
    tick();
    chk("ori_aluop", ex_aluop, 4);
    chk("ori_op1", ex_op1, 0);
    chk("ori_op2", ex_op2, 32'h000000ff);
    chk("ori_waddr", ex_waddr, 1);
    chk("ori_we", ex_we, 1);

    // ADDU r3,r1,r2 with EX and MEM both holding r1
    id_inst = 32'h00221821; rdata1 = 32'h99; rdata2 = 32'h5;
    exf_we = 1'b1; exf_waddr = 5'd1; exf_wdata = 32'h11;
    memf_we = 1'b1; memf_waddr = 5'd1; memf_wdata = 32'h22;
    #1;
    chk("addu_re2", re2, 1);
    chk("addu_raddr2", raddr2, 2);
    tick();
    chk("addu_op1_exwins", ex_op1, 32'h11);
    chk("addu_op2", ex_op2, 5);
    chk("addu_aluop", ex_aluop, 1);
    chk("addu_waddr", ex_waddr, 3);

    // ADDU r3,r0,r1 with EX claiming a write to r0
    id_inst = 32'h00011821; rdata1 = 32'h77; rdata2 = 32'h7;
    exf_we = 1'b1; exf_waddr = 5'd0; exf_wdata = 32'hdead;
    memf_we = 1'b0;
    tick();
    chk("r0_op1_zero", ex_op1, 0);
    chk("r0_op2", ex_op2, 7);

    // MEM-only forwarding on rt
    id_inst = 32'h00221821; rdata1 = 32'h99; rdata2 = 32'h5;
    exf_we = 1'b0; memf_we = 1'b1; memf_waddr = 5'd2; memf_wdata = 32'h22;
    tick();
    chk("memfwd_op1", ex_op1, 32'h99);
    chk("memfwd_op2", ex_op2, 32'h22);

    // LUI r6,0x1234
    fwd_off();
    id_inst = 32'h3C061234;
    tick();
    chk("lui_aluop", ex_aluop, 7);
    chk("lui_op1", ex_op1, 0);
    chk("lui_op2", ex_op2, 32'h12340000);
    chk("lui_waddr", ex_waddr, 6);

    // SW r2,8(r1)
    id_inst = 32'hAC220008; rdata1 = 32'h1000; rdata2 = 32'hCAFE;
    tick();
    chk("sw_op1", ex_op1, 32'h1000);
    chk("sw_op2", ex_op2, 8);
    chk("sw_store", ex_store_data, 32'hCAFE);
    chk("sw_mem_we", ex_mem_we, 1);
    chk("sw_we", ex_we, 0);

    // ADDIU r7,r1,-1
    id_inst = 32'h2427FFFF;
    tick();
    chk("addiu_op2_sext", ex_op2, 32'hFFFFFFFF);
    chk("addiu_waddr", ex_waddr, 7);
    chk("addiu_store_zero", ex_store_data, 0);

    // ADDU r0,r1,r2: write to r0 suppressed
    id_inst = 32'h00220021;
    tick();
    chk("r0dest_we", ex_we, 0);

    // LW r4,0(r1)
    id_inst = 32'h8C240000; rdata1 = 32'h200;
    tick();
    chk("lw_mem_re", ex_mem_re, 1);
    chk("lw_waddr", ex_waddr, 4);
    chk("lw_op1", ex_op1, 32'h200);
    chk("lw_we", ex_we, 1);

    // ADDU r5,r4,r4 behind the load, with downstream stall first
    id_inst = 32'h00842821; stall_in = 1'b1;
    #1;
    chk("lu_stall_req", stall_req, 1);
    tick();
    chk("hold_mem_re", ex_mem_re, 1);
    chk("hold_waddr", ex_waddr, 4);
    chk("hold_op1", ex_op1, 32'h200);
    stall_in = 1'b0;
    #1;
    chk("lu_stall_req2", stall_req, 1);
    tick();
    chk("bubble_we", ex_we, 0);
    chk("bubble_mem_re", ex_mem_re, 0);
    chk("bubble_aluop", ex_aluop, 0);
    chk("lu_stall_clear", stall_req, 0);
    memf_we = 1'b1; memf_waddr = 5'd4; memf_wdata = 32'h55;
    tick();
    chk("lu_addu_aluop", ex_aluop, 1);
    chk("lu_addu_op1", ex_op1, 32'h55);
    chk("lu_addu_op2", ex_op2, 32'h55);
    chk("lu_addu_waddr", ex_waddr, 5);

    // BEQ r1,r2,+4 at 0x100 with forwarded operands
    id_inst = 32'h10220004; id_pc = 32'h100;
    exf_we = 1'b1; exf_waddr = 5'd1; exf_wdata = 32'h33;
    memf_we = 1'b1; memf_waddr = 5'd2; memf_wdata = 32'h33;
    #1;
    chk("beq_taken", br_taken, 1);
    chk("beq_target", br_target, 32'h114);
    memf_wdata = 32'h34;
    #1;
    chk("beq_not_taken", br_taken, 0);
    id_inst = 32'h1422FFFF;
    #1;
    chk("bne_taken", br_taken, 1);
    chk("bne_target_neg", br_target, 32'h100);
    tick();
    chk("br_we", ex_we, 0);

    // flush together with stall_in loads a bubble
    fwd_off();
    id_inst = 32'h340100ff;
    tick();
    chk("pre_flush_we", ex_we, 1);
    flush = 1'b1; stall_in = 1'b1;
    tick();
    chk("flush_we", ex_we, 0);
    chk("flush_op2", ex_op2, 0);
    chk("flush_aluop", ex_aluop, 0);
    flush = 1'b0; stall_in = 1'b0;

    // not-valid cycle loads a bubble
    tick();
    id_valid = 1'b0;
    tick();
    chk("novalid_we", ex_we, 0);
    chk("novalid_op2", ex_op2, 0);
    id_valid = 1'b1;

    // unknown opcode 0x3f
    id_inst = 32'hFC000000;
    tick();
    chk("inv_flag", ex_invalid, 1);
    chk("inv_we", ex_we, 0);
    chk("inv_aluop", ex_aluop, 0);

    // asynchronous reset mid-stream
    id_inst = 32'h340100ff;
    tick();
    chk("pre_rst_we", ex_we, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_we", ex_we, 0);
    chk("arst_op2", ex_op2, 0);
    chk("arst_waddr", ex_waddr, 0);
    chk("arst_aluop", ex_aluop, 0);
    @(negedge clk);
    rst = 1'b0;
    id_inst = 32'h34020ABC;
    tick();
    chk("post_rst_op2", ex_op2, 32'h00000ABC);
    chk("post_rst_waddr", ex_waddr, 2);
    chk("post_rst_we", ex_we, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
